// File: rtl/irq_port_hub.sv
// Interrupt and port-register hub: latches peripheral request edges, masks and prioritises
// them, drives intr to the 8080 core and supplies an RST opcode on acknowledge.
module irq_port_hub #(
  parameter int         CHANNELS  = 4,
  parameter logic [7:0] PORT_BASE = 8'h10,
  parameter int         RST_BASE  = 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [CHANNELS-1:0] irq_req,
  input  logic [7:0]          port_a,
  input  logic [7:0]          port_o,
  input  logic                port_we,
  input  logic                port_rd,
  output logic [7:0]          port_i,
  output logic                port_hit,
  input  logic                iff1,
  output logic                intr,
  input  logic                inta,
  output logic [7:0]          vector,
  output logic [CHANNELS-1:0] in_service
);

  localparam int CW = CHANNELS;

  if (CHANNELS < 1 || CHANNELS > 8 || RST_BASE < 0 || RST_BASE + CHANNELS > 8) begin : g_bad_cfg
    $error("irq_port_hub: CHANNELS must be 1..8 and RST_BASE+CHANNELS must not exceed 8");
  end

  function automatic logic [CW-1:0] lowest_one(input logic [CW-1:0] v);
    return v & (~v + CW'(1));
  endfunction

  function automatic logic [7:0] rst_opcode(input logic [2:0] idx);
    logic [2:0] n;
    n = 3'(RST_BASE) + idx;
    return 8'hC7 | {2'b00, n, 3'b000};
  endfunction

  logic [CW-1:0] req_sync_p0, req_sync_p1, req_prev_p2, req_edge;
  logic [CW-1:0] mask_q, pend_q, isr_q, mask_d, pend_d, isr_d;
  logic [1:0]    ctrl_q, ctrl_d;
  logic [7:0]    vector_q, vector_d, rd_mux;
  logic          intr_q, intr_d;
  logic [8:0]    addr_diff;
  logic [1:0]    reg_off;
  logic          wr_en, ack_ok;
  logic [CW-1:0] isr_low, prio_mask, elig, elig_low;
  logic [2:0]    elig_idx;
  logic [8:0]    unused_bits;

  // Read strobe has no side effects; upper write-data bits are ignored for narrow hubs.
  assign unused_bits = {port_rd, port_o};

  // A 9-bit difference keeps addresses below PORT_BASE from wrapping into the window.
  assign addr_diff = {1'b0, port_a} - {1'b0, PORT_BASE};
  assign port_hit  = (addr_diff < 9'd4);
  assign reg_off   = addr_diff[1:0];
  assign wr_en     = port_we & port_hit;
  assign req_edge  = req_sync_p1 & ~req_prev_p2;

  always_comb begin
    isr_low   = lowest_one(isr_q);
    prio_mask = (isr_q == '0) ? '1 : (isr_low - CW'(1));
    elig      = pend_q & mask_q & prio_mask;
    elig_low  = lowest_one(elig);
    ack_ok    = inta & (elig != '0);
    elig_idx  = 3'd0;
    for (int i = CW - 1; i >= 0; i--) begin
      if (elig[i]) elig_idx = 3'(i);
    end
  end

  always_comb begin
    mask_d   = mask_q;
    pend_d   = pend_q;
    isr_d    = isr_q;
    ctrl_d   = ctrl_q;
    vector_d = vector_q;
    intr_d   = ctrl_q[0] & iff1 & (elig != '0);
    if (wr_en) begin
      case (reg_off)
        2'd0:    mask_d = port_o[CW-1:0];
        2'd1:    pend_d = pend_q & ~port_o[CW-1:0];
        2'd2:    isr_d  = isr_q & ~isr_low;
        default: ctrl_d = port_o[1:0];
      endcase
    end
    if (inta) vector_d = ack_ok ? rst_opcode(elig_idx) : 8'hFF;
    if (ack_ok) begin
      pend_d = pend_d & ~elig_low;
      if (!ctrl_q[1]) isr_d = isr_d | elig_low;
    end
    // A fresh edge outranks any clear landing in the same cycle.
    pend_d = pend_d | req_edge;
  end

  always_comb begin
    rd_mux = 8'h00;
    case (reg_off)
      2'd0:    rd_mux[CW-1:0] = mask_q;
      2'd1:    rd_mux[CW-1:0] = pend_q;
      2'd2:    rd_mux[CW-1:0] = isr_q;
      default: rd_mux[1:0]    = ctrl_q;
    endcase
    port_i = port_hit ? rd_mux : 8'hFF;
  end

  // Stage p0..p2: request synchroniser and edge-history flops
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      req_sync_p0 <= '0;
      req_sync_p1 <= '0;
      req_prev_p2 <= '0;
    end else begin
      req_sync_p0 <= irq_req;
      req_sync_p1 <= req_sync_p0;
      req_prev_p2 <= req_sync_p1;
    end
  end

  // Register file, vector and intr state
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mask_q   <= '0;
      pend_q   <= '0;
      isr_q    <= '0;
      ctrl_q   <= 2'b00;
      vector_q <= 8'hFF;
      intr_q   <= 1'b0;
    end else begin
      mask_q   <= mask_d;
      pend_q   <= pend_d;
      isr_q    <= isr_d;
      ctrl_q   <= ctrl_d;
      vector_q <= vector_d;
      intr_q   <= intr_d;
    end
  end

  assign intr       = intr_q;
  assign vector     = vector_q;
  assign in_service = isr_q;

endmodule

// File: tb/tb_irq_port_hub.sv
// Bench for irq_port_hub: directed scenarios plus a randomized run against a behavioural model.
module tb_irq_port_hub;
  localparam int         CH   = 4;
  localparam logic [7:0] BASE = 8'h10;
  localparam int         RB   = 1;

  logic          clock = 1'b0;
  logic          reset;
  logic [CH-1:0] irq_req;
  logic [7:0]    port_a, port_o, port_i, vector;
  logic          port_we, port_rd, port_hit, iff1, intr, inta;
  logic [CH-1:0] in_service;

  int checks   = 0;
  int failures = 0;

  irq_port_hub #(.CHANNELS(CH), .PORT_BASE(BASE), .RST_BASE(RB)) dut (
    .clock(clock), .reset(reset), .irq_req(irq_req), .port_a(port_a), .port_o(port_o),
    .port_we(port_we), .port_rd(port_rd), .port_i(port_i), .port_hit(port_hit),
    .iff1(iff1), .intr(intr), .inta(inta), .vector(vector), .in_service(in_service)
  );

  always #5 clock = ~clock;

  // Behavioural model: per-channel flags, request history by clock edge.
  bit         m_mask[CH], m_pend[CH], m_isr[CH];
  bit         m_gen, m_aeoi, m_intr;
  logic [7:0] m_vector;
  bit         h1[CH], h2[CH], h3[CH];

  function automatic void model_reset();
    for (int c = 0; c < CH; c++) begin
      m_mask[c] = 0; m_pend[c] = 0; m_isr[c] = 0; h1[c] = 0; h2[c] = 0; h3[c] = 0;
    end
    m_gen = 0; m_aeoi = 0; m_intr = 0; m_vector = 8'hFF;
  endfunction

  function automatic int first_isr();
    for (int c = 0; c < CH; c++) if (m_isr[c]) return c;
    return CH;
  endfunction

  function automatic int pick_channel();
    int li = first_isr();
    for (int c = 0; c < li; c++) if (m_pend[c] && m_mask[c]) return c;
    return -1;
  endfunction

  function automatic void model_edge();
    int  k = pick_channel();
    int  li = first_isr();
    int  pa = int'(port_a);
    bit  hit = (pa >= int'(BASE)) && (pa < int'(BASE) + 4);
    int  off = pa - int'(BASE);
    bit  old_aeoi = m_aeoi;
    bit  rise[CH];
    for (int c = 0; c < CH; c++) rise[c] = h2[c] && !h3[c];
    m_intr = m_gen && iff1 && (k >= 0);
    if (inta) begin
      if (k >= 0) begin
        m_vector = 8'(32'hC7 | ((RB + k) * 8));
        m_pend[k] = 0;
      end else m_vector = 8'hFF;
    end
    if (port_we && hit) begin
      case (off)
        0: for (int c = 0; c < CH; c++) m_mask[c] = port_o[c];
        1: for (int c = 0; c < CH; c++) if (port_o[c]) m_pend[c] = 0;
        2: if (li < CH) m_isr[li] = 0;
        default: begin m_gen = port_o[0]; m_aeoi = port_o[1]; end
      endcase
    end
    if (inta && k >= 0 && !old_aeoi) m_isr[k] = 1;
    for (int c = 0; c < CH; c++) begin
      if (rise[c]) m_pend[c] = 1;
      h3[c] = h2[c]; h2[c] = h1[c]; h1[c] = irq_req[c];
    end
  endfunction

  function automatic logic [7:0] model_reg(input int off);
    logic [7:0] r = 8'h00;
    for (int c = 0; c < CH; c++) begin
      if (off == 0) r[c] = m_mask[c];
      if (off == 1) r[c] = m_pend[c];
      if (off == 2) r[c] = m_isr[c];
    end
    if (off == 3) r = {6'b0, m_aeoi, m_gen};
    if (off > 3) r = 8'hFF;
    return r;
  endfunction

  function automatic logic [CH-1:0] model_isr_vec();
    logic [CH-1:0] v;
    for (int c = 0; c < CH; c++) v[c] = m_isr[c];
    return v;
  endfunction

  task automatic tick();
    @(posedge clock);
    model_edge();
    #1;
    port_we = 0; inta = 0; port_a = 8'h00; port_o = 8'h00;
  endtask

  task automatic wr(input int off, input logic [7:0] data);
    port_a = BASE + 8'(off); port_o = data; port_we = 1;
    tick();
  endtask

  task automatic ack();
    inta = 1;
    tick();
  endtask

  task automatic do_reset();
    reset = 1; model_reset(); #2; reset = 0;
  endtask

  task automatic test_reset();
    irq_req = '0; port_a = 8'h00; port_o = 8'h00; port_we = 0; port_rd = 0; iff1 = 0; inta = 0;
    reset = 1; model_reset();
    #12;
    checks++; if (intr !== 1'b0) begin failures++; $display("FAIL reset_intr got=%b exp=0", intr); end
    checks++; if (vector !== 8'hFF) begin failures++; $display("FAIL reset_vector got=%h exp=ff", vector); end
    checks++; if (in_service !== '0) begin failures++; $display("FAIL reset_isr got=%h exp=0", in_service); end
    reset = 0;
    for (int off = 0; off < 4; off++) begin
      port_a = BASE + 8'(off); #1;
      checks++; if (port_i !== 8'h00) begin failures++; $display("FAIL reset_reg%0d got=%h exp=00", off, port_i); end
    end
    port_a = 8'h00;
  endtask

  task automatic test_basic();
    do_reset();
    wr(3, 8'h01); wr(0, 8'h0F); iff1 = 1;
    irq_req[2] = 1;
    tick(); tick(); tick();
    port_a = BASE + 8'd1; #1;
    checks++; if (port_i !== 8'h04) begin failures++; $display("FAIL basic_pend got=%h exp=04", port_i); end
    checks++; if (intr !== 1'b0) begin failures++; $display("FAIL basic_intr_early got=%b exp=0", intr); end
    tick();
    checks++; if (intr !== 1'b1) begin failures++; $display("FAIL basic_intr got=%b exp=1", intr); end
    ack();
    irq_req[2] = 0;
    checks++; if (vector !== 8'hDF) begin failures++; $display("FAIL basic_vector got=%h exp=df", vector); end
    checks++; if (in_service !== 4'h4) begin failures++; $display("FAIL basic_isr got=%h exp=4", in_service); end
    port_a = BASE + 8'd1; #1;
    checks++; if (port_i !== 8'h00) begin failures++; $display("FAIL basic_pend_clr got=%h exp=00", port_i); end
  endtask

  task automatic test_nested();
    do_reset();
    wr(3, 8'h01); wr(0, 8'h0F); iff1 = 1;
    irq_req = 4'b1010;
    for (int i = 0; i < 4; i++) tick();
    checks++; if (intr !== 1'b1) begin failures++; $display("FAIL nested_intr got=%b exp=1", intr); end
    ack();
    irq_req = '0;
    checks++; if (vector !== 8'hD7) begin failures++; $display("FAIL nested_vec1 got=%h exp=d7", vector); end
    tick(); tick();
    checks++; if (intr !== 1'b0) begin failures++; $display("FAIL nested_blocked got=%b exp=0", intr); end
    wr(2, 8'h00); tick();
    checks++; if (intr !== 1'b1) begin failures++; $display("FAIL nested_after_eoi got=%b exp=1", intr); end
    ack();
    checks++; if (vector !== 8'hE7) begin failures++; $display("FAIL nested_vec2 got=%h exp=e7", vector); end
    checks++; if (in_service !== 4'h8) begin failures++; $display("FAIL nested_isr got=%h exp=8", in_service); end
  endtask

  task automatic test_aeoi();
    do_reset();
    wr(3, 8'h03); wr(0, 8'h01); iff1 = 1;
    irq_req[0] = 1;
    for (int i = 0; i < 4; i++) tick();
    ack();
    checks++; if (vector !== 8'hCF) begin failures++; $display("FAIL aeoi_vector got=%h exp=cf", vector); end
    checks++; if (in_service !== '0) begin failures++; $display("FAIL aeoi_isr got=%h exp=0", in_service); end
    for (int i = 0; i < 6; i++) tick();
    checks++; if (intr !== 1'b0) begin failures++; $display("FAIL aeoi_held_level got=%b exp=0", intr); end
    irq_req[0] = 0;
  endtask

  task automatic test_collision();
    do_reset();
    wr(3, 8'h01); wr(0, 8'h0F); iff1 = 1;
    irq_req[2] = 1;
    tick(); tick();
    wr(1, 8'h04);
    port_a = BASE + 8'd1; #1;
    checks++; if (port_i !== 8'h04) begin failures++; $display("FAIL collide_pend got=%h exp=04", port_i); end
    irq_req[2] = 0;
    wr(0, 8'h00); tick();
    ack();
    checks++; if (vector !== 8'hFF) begin failures++; $display("FAIL spurious_vector got=%h exp=ff", vector); end
    checks++; if (in_service !== '0) begin failures++; $display("FAIL spurious_isr got=%h exp=0", in_service); end
  endtask

  task automatic test_iff1_reset();
    do_reset();
    wr(3, 8'h01); wr(0, 8'h01); iff1 = 0;
    irq_req[0] = 1;
    for (int i = 0; i < 5; i++) tick();
    checks++; if (intr !== 1'b0) begin failures++; $display("FAIL iff1_low got=%b exp=0", intr); end
    iff1 = 1; tick();
    checks++; if (intr !== 1'b1) begin failures++; $display("FAIL iff1_high got=%b exp=1", intr); end
    ack();
    checks++; if (vector !== 8'hCF) begin failures++; $display("FAIL iff1_vector got=%h exp=cf", vector); end
    inta = 1; #2; reset = 1; model_reset(); #1;
    checks++; if (vector !== 8'hFF) begin failures++; $display("FAIL midreset_vector got=%h exp=ff", vector); end
    checks++; if (intr !== 1'b0) begin failures++; $display("FAIL midreset_intr got=%b exp=0", intr); end
    checks++; if (in_service !== '0) begin failures++; $display("FAIL midreset_isr got=%h exp=0", in_service); end
    port_a = BASE + 8'd3; #1;
    checks++; if (port_i !== 8'h00) begin failures++; $display("FAIL midreset_ctrl got=%h exp=00", port_i); end
    reset = 0; inta = 0; irq_req = '0; port_a = 8'h00;
  endtask

  task automatic test_port_decode();
    do_reset();
    wr(3, 8'hFF); wr(0, 8'h05);
    port_a = 8'h13; #1;
    checks++; if (port_i !== 8'h03 || port_hit !== 1'b1) begin
      failures++; $display("FAIL decode_ctrl got=%h/%b exp=03/1", port_i, port_hit); end
    port_a = 8'h14; #1;
    checks++; if (port_i !== 8'hFF || port_hit !== 1'b0) begin
      failures++; $display("FAIL decode_14 got=%h/%b exp=ff/0", port_i, port_hit); end
    port_a = 8'h0F; #1;
    checks++; if (port_hit !== 1'b0) begin failures++; $display("FAIL decode_0f got=%b exp=0", port_hit); end
    port_a = 8'h14; port_o = 8'h00; port_we = 1; tick();
    port_a = 8'h10; #1;
    checks++; if (port_i !== 8'h05) begin failures++; $display("FAIL decode_nowrite got=%h exp=05", port_i); end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 600; n++) begin
      int off;
      for (int c = 0; c < CH; c++) if ($urandom_range(7) == 0) irq_req[c] = ~irq_req[c];
      iff1 = ($urandom_range(3) != 0);
      inta = ($urandom_range(5) == 0);
      if ($urandom_range(4) == 0) begin
        port_we = 1; port_a = BASE + 8'($urandom_range(4)); port_o = 8'($urandom);
        if (port_a == BASE + 8'd3) port_o[0] = ($urandom_range(3) != 0);
      end
      port_rd = $urandom_range(1);
      tick();
      checks++; if (intr !== m_intr) begin failures++; $display("FAIL rand_intr n=%0d got=%b exp=%b", n, intr, m_intr); end
      checks++; if (vector !== m_vector) begin failures++; $display("FAIL rand_vector n=%0d got=%h exp=%h", n, vector, m_vector); end
      checks++; if (in_service !== model_isr_vec()) begin
        failures++; $display("FAIL rand_isr n=%0d got=%h exp=%h", n, in_service, model_isr_vec()); end
      off = $urandom_range(4);
      port_a = BASE + 8'(off); #1;
      checks++; if (port_i !== model_reg(off)) begin
        failures++; $display("FAIL rand_read n=%0d off=%0d got=%h exp=%h", n, off, port_i, model_reg(off)); end
    end
    irq_req = '0; port_rd = 0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_nested();
    test_aeoi();
    test_collision();
    test_iff1_reset();
    test_port_decode();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/irq_port_hub.md
# irq_port_hub

Parametrised interrupt and port-register hub for the LCR580 system. It collects up to eight peripheral interrupt requests (keyboard, timer, UART, VGA frame) and latches them as pending. It masks and prioritises them, raises a single `intr` toward the CPU, and on acknowledge supplies an 8080 `RST n` opcode. It replaces the ad-hoc keyboard toggle-pair IRQ flag in the top level and sits between the peripherals and the CPU port bus, sharing `port_a`/`port_we`/`port_rd` with other port decoders.

## Interface
- `CHANNELS`, 4: number of request lines, 1..8; channel 0 has highest priority.
- `PORT_BASE`, 8'h10: first of four consecutive I/O port addresses.
- `RST_BASE`, 1: RST number of channel 0. Elaboration error if `RST_BASE+CHANNELS > 8`.

Ports:
- `clock`  in  1  system clock (25 MHz CPU clock).
- `reset`  in  1  asynchronous, active-high reset.
- `irq_req`  in  CHANNELS  request lines, asynchronous to `clock`; a rising edge is a request.
- `port_a`  in  8  CPU port address.
- `port_o`  in  8  CPU write data.
- `port_we`  in  1  one-cycle port write strobe.
- `port_rd`  in  1  one-cycle port read strobe.
- `port_i`  out  8  read data, combinational from `port_a`; 8'hFF when not hit.
- `port_hit`  out  1  `port_a` within PORT_BASE..PORT_BASE+3.
- `iff1`  in  1  CPU interrupt-enable flag.
- `intr`  out  1  registered interrupt request to the CPU.
- `inta`  in  1  one-cycle interrupt acknowledge.
- `vector`  out  8  RST opcode for the acknowledged channel.
- `in_service`  out  CHANNELS  in-service bits.

## Operation
- Registers (offset from PORT_BASE):
  - +0 MASK, R/W; 1 = channel enabled.
  - +1 PEND, R; writing 1 clears that bit.
  - +2 ISR, R; a write of any value is EOI and clears the lowest-index set ISR bit.
  - +3 CTRL, R/W; bit0 GEN (global enable), bit1 AEOI (auto-EOI), other bits read 0.
- Unused high bits of MASK/PEND/ISR read 0.
- Request path: each `irq_req` bit passes through a 2-flop synchroniser, then a rising-edge detector on the synchronised value. An edge sets PEND[k]. A level held high does not re-trigger.
- Eligible set: E = PEND & MASK, restricted to channels with index lower than the lowest set ISR bit (all channels when ISR = 0).
- `intr` next = GEN & `iff1` & (E != 0). `inta` never clears `intr` combinationally; `intr` is re-evaluated next cycle.
- On `inta` with E != 0, let k = lowest set bit of E:
  - `vector` <= 8'hC7 | ((RST_BASE+k) << 3);
  - PEND[k] <= 0;
  - ISR[k] <= 1 unless AEOI = 1.
- On `inta` with E = 0 (spurious): `vector` <= 8'hFF (RST 7); no register changes.
- `vector` holds its value until the next `inta`.
- Simultaneous events:
  - Edge on k in the same cycle as a PEND[k] clear (W1C or `inta`): the edge wins and PEND[k] stays 1.
  - EOI write in the same cycle as `inta` setting ISR[j]: the EOI clears the lowest set bit of the pre-update ISR, then ISR[j] is set.
  - MASK write in the same cycle as `inta`: `inta` uses the old MASK.
- Writes apply only when `port_we` & `port_hit`. `port_rd` has no side effects.

## Timing
- Reset (asynchronous, any cycle, including mid-acknowledge): MASK = 0, PEND = 0, ISR = 0, CTRL = 0, synchronisers = 0, `intr` = 0, `vector` = 8'hFF.
- `irq_req` rising before edge C0: PEND set after C2, `intr` high after C3 (3 cycles), given GEN, MASK and `iff1` are already 1.
- `inta` at edge N: `vector`, PEND and ISR update at N; `intr` reflects the new state at N+1.
- Register writes take effect at the strobe edge. `intr` reflects the change one cycle later.
- `port_i` and `port_hit` are purely combinational with zero latency.

## Test plan
- Reset, then CTRL=1, MASK=8'h0F, pulse `irq_req[2]`, `iff1`=1 → `intr`=1 three cycles after the edge; `inta` → `vector`=8'hDF (RST 3), PEND=0, ISR=8'h04.
- Channels 1 and 3 pending, MASK=8'h0F → first `inta` gives 8'hD7 (ch1); with ISR[1] set, ch3 is blocked (`intr`=0) until an EOI write to +2, then `intr`=1 and the second `inta` gives 8'hE7.
- AEOI=1, pulse ch0 → `inta` gives 8'hCF and ISR stays 0; `irq_req[0]` held high yields no second request.
- Edge on ch2 in the same cycle as a W1C write of 8'h04 to +1 → PEND[2]=1 afterwards; `inta` with E=0 → `vector`=8'hFF.
- `iff1`=0 with ch0 pending → `intr`=0; raise `iff1` → `intr`=1 next cycle; assert `reset` mid-sequence → all registers 0 and `vector`=8'hFF immediately.
- Port decode: `port_a`=8'h13 reads CTRL; `port_a`=8'h14 → `port_hit`=0 and `port_i`=8'hFF; writes to 8'h14 change nothing.
